// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 definitions: controller state encoding, line
//               synchronizer depth, frame length and the parity helper.
//               Used by the host transmitter and the keyboard receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQUEST   = 3'd2,
    SEND      = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_t;

  // Flops between the raw pad and the first use of the line value.
  localparam int PS2_SYNC_STAGES = 2;

  // start + 8 data + parity + stop (host-to-device: stop slot is the ack clock)
  localparam int PS2_FRAME_LEN = 11;

  // Parity bit that gives data+parity an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Multi-flop synchronizer for one raw PS/2 line plus a falling
//               edge detector on the synchronized value.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int STAGES = PS2_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_line_sync,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the raw line through the synchronizer; idle PS/2 lines are high,
  // so reset to 1 to avoid a false edge when reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_line};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_line_sync = r_sync[STAGES-1];
  assign o_fall      = r_prev & ~r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter. Inhibits the clock,
//               issues the request-to-send, shifts out data/parity/stop on
//               device clock falls, checks the device ack and reports
//               done / error. Open-drain outputs: oe=1 pulls the line low.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int         c_INH_W   = $clog2(INHIBIT_CYCLES + 1);
  localparam int         c_TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] c_ACK_BIT = 4'(PS2_FRAME_LEN - 1);
  localparam logic [3:0] c_STOP_BIT = 4'(PS2_FRAME_LEN - 2);

  ps2_state_t         r_state;
  ps2_state_t         w_state_nxt;
  logic [9:0]         r_frame;       // {stop, parity, data[7:0]}
  logic [3:0]         r_bit_n;
  logic [c_INH_W-1:0] r_inh_cnt;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_data_oe;
  logic               r_err_flag;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_data_fall_unused;
  logic w_clk_oe;
  logic w_done;
  logic w_err;
  logic w_tmo_hit;

  ps2_line_sync #(.STAGES(PS2_SYNC_STAGES)) u_clk_sync (
    .clk         (system_clk),
    .rst_n       (reset),
    .i_line      (PS2_clk),
    .o_line_sync (w_clk_sync),
    .o_fall      (w_clk_fall)
  );

  ps2_line_sync #(.STAGES(PS2_SYNC_STAGES)) u_data_sync (
    .clk         (system_clk),
    .rst_n       (reset),
    .i_line      (PS2_data),
    .o_line_sync (w_data_sync),
    .o_fall      (w_data_fall_unused)
  );

  assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES));

  // State register; reset drops straight to IDLE so both lines release at once.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus the state-derived clock drive and result pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_clk_oe    = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_valid) w_state_nxt = INHIBIT;
      end
      INHIBIT: begin
        w_clk_oe = 1'b1;
        if (r_inh_cnt == '0) w_state_nxt = REQUEST;
      end
      REQUEST: begin
        w_clk_oe    = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_clk_fall && (r_bit_n == c_ACK_BIT)) begin
          w_state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (w_clk_sync && w_data_sync) begin
          w_done      = ~r_err_flag;
          w_err       = r_err_flag;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame capture, counters, data-line drive and ack bookkeeping.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_frame    <= '0;
      r_bit_n    <= '0;
      r_inh_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_data_oe  <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_data_oe <= 1'b0;
          if (tx_valid) begin
            r_frame   <= {1'b1, ps2_odd_parity(tx_data), tx_data};
            r_inh_cnt <= c_INH_W'(INHIBIT_CYCLES - 1);
          end
        end
        INHIBIT: begin
          if (r_inh_cnt != '0) r_inh_cnt <= r_inh_cnt - 1'b1;
          else                 r_data_oe <= 1'b1;   // start bit for REQUEST
        end
        REQUEST: begin
          r_bit_n   <= '0;
          r_tmo_cnt <= '0;
        end
        SEND: begin
          if (w_tmo_hit) begin
            r_data_oe <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_clk_fall) begin
              if (r_bit_n <= c_STOP_BIT) begin
                // Stop bit is 1 in the frame, so this releases the line.
                r_data_oe <= ~r_frame[r_bit_n];
                r_bit_n   <= r_bit_n + 4'd1;
              end else begin
                // Ack slot: device should be holding data low.
                r_err_flag <= w_data_sync;
                r_data_oe  <= 1'b0;
              end
            end
          end
        end
        WAIT_IDLE: begin
          r_data_oe <= 1'b0;
          if (w_clk_sync && w_data_sync) r_err_flag <= 1'b0;
        end
        default: r_data_oe <= 1'b0;
      endcase
    end
  end

  assign tx_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign ps2_clk_oe  = w_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_done     = w_done;
  assign tx_error    = w_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed bench for ps2_host_tx with a behavioural PS/2
//               device (40-cycle clock, samples on rising edges, optional
//               ack) and a queue of expected frames / outcomes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_pulse = 0;

  logic [9:0] q_frame[$];
  bit         q_ok[$];

  // Wired-AND open-drain bus shared by host and device.
  assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .system_clk  (clk),
    .reset       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .PS2_clk     (ps2_clk_line),
    .PS2_data    (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Count result pulses; done and error must never coincide.
  always @(negedge clk) begin
    if (tx_done || tx_error) begin
      n_pulse++;
      n_cmp++;
      assert (!(tx_done && tx_error)) else begin
        n_bad++;
        $error("FAIL pulse_overlap: observed done=%0b error=%0b, required not both", tx_done, tx_error);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, logic'((ones % 2) == 0), b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] b, input bit hold, input bit ok);
    int i = 0;
    while (!tx_ready && i < 2000) begin tick(); i++; end
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    if (!hold) tx_valid = 1'b0;
    q_frame.push_back(exp_frame(b));
    q_ok.push_back(ok);
    check("busy_after_accept", busy, 1);
    check("clk_oe_after_accept", ps2_clk_oe, 1);
  endtask

  task automatic inhibit_len();
    int cnt = 0;
    while (ps2_clk_oe && cnt < 1000) begin cnt++; tick(); end
    check("inhibit_len", cnt, INH + 1);
  endtask

  task automatic dev_clock(output logic b);
    dev_clk_low = 1'b1;
    repeat (20) tick();
    dev_clk_low = 1'b0;
    b = ps2_data_line;
    repeat (20) tick();
  endtask

  task automatic dev_frame(input bit ack, output logic [9:0] rx);
    logic b;
    logic [9:0] exp;
    repeat (10) tick();
    for (int k = 0; k < 10; k++) begin
      dev_clock(b);
      rx[k] = b;
    end
    if (ack) dev_dat_low = 1'b1;
    repeat (5) tick();
    dev_clk_low = 1'b1;
    repeat (20) tick();
    dev_clk_low = 1'b0;
    if (ack) begin
      repeat (5) tick();
      dev_dat_low = 1'b0;
    end
    exp = q_frame.pop_front();
    check("frame_bits", rx, exp);
  endtask

  task automatic expect_result();
    bit ok;
    int i = 0;
    ok = q_ok.pop_front();
    while (!(tx_done || tx_error) && i < 500) begin tick(); i++; end
    check("tx_done", tx_done, ok);
    check("tx_error", tx_error, !ok);
    tick();
    check("ready_after_pulse", tx_ready, 1);
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, output logic [9:0] rx);
    accept(b, 1'b0, ack);
    inhibit_len();
    dev_frame(ack, rx);
    expect_result();
  endtask

  initial begin
    logic [9:0] rx;
    logic       b;
    int         c0, c1, i, p0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 0xED: bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1
    p0 = n_pulse;
    xfer(8'hED, 1'b1, rx);
    check("ed_data", rx[7:0], 8'hED);
    check("ed_parity", rx[8], 1);
    check("ed_stop", rx[9], 1);
    check("ed_one_pulse", n_pulse - p0, 1);

    xfer(8'h01, 1'b1, rx);
    check("x01_parity", rx[8], 0);
    xfer(8'hFF, 1'b1, rx);
    check("xff_parity", rx[8], 1);

    // Device never clocks: timeout measured from first SEND cycle
    accept(8'h12, 1'b0, 1'b0);
    inhibit_len();
    c0 = cyc;
    i = 0;
    while (!tx_error && i < TMO + 100) begin tick(); i++; end
    c1 = cyc;
    check("timeout_error", tx_error, 1);
    check("timeout_no_done", tx_done, 0);
    check("timeout_cycles", c1 - c0, TMO);
    void'(q_frame.pop_front());
    void'(q_ok.pop_front());
    tick();
    check("timeout_ready", tx_ready, 1);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_data_oe", ps2_data_oe, 0);

    // Device leaves data high in the ack slot
    p0 = n_pulse;
    xfer(8'h3A, 1'b0, rx);
    check("nack_one_pulse", n_pulse - p0, 1);

    // Reset during bit 4 (0x0F has bit4=0, so data is being driven low)
    accept(8'h0F, 1'b0, 1'b1);
    inhibit_len();
    repeat (10) tick();
    for (int k = 0; k < 4; k++) dev_clock(b);
    dev_clk_low = 1'b1;
    repeat (10) tick();
    check("pre_reset_data_oe", ps2_data_oe, 1);
    p0 = n_pulse;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_oe", ps2_clk_oe, 0);
    check("async_rst_data_oe", ps2_data_oe, 0);
    check("async_rst_busy", busy, 0);
    repeat (3) tick();
    dev_clk_low = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    check("reset_no_pulse", n_pulse - p0, 0);
    q_frame.delete();
    q_ok.delete();

    xfer(8'hF4, 1'b1, rx);
    check("f4_data", rx[7:0], 8'hF4);

    // tx_valid held with changing data: only the first byte goes out
    accept(8'hA5, 1'b1, 1'b1);
    tx_data = 8'h3C;
    inhibit_len();
    dev_frame(1'b1, rx);
    check("hold_first_data", rx[7:0], 8'hA5);
    expect_result();
    q_frame.push_back(exp_frame(8'h3C));
    q_ok.push_back(1'b1);
    tick();
    check("hold_second_busy", busy, 1);
    check("hold_second_clk_oe", ps2_clk_oe, 1);
    tx_valid = 1'b0;
    inhibit_len();
    dev_frame(1'b1, rx);
    check("hold_second_data", rx[7:0], 8'h3C);
    expect_result();

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the system to the keyboard over the shared open-collector PS2_clk/PS2_data pair. It runs the full host request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, then device acknowledge. It sits beside the keyboard receiver in the keyboard peripheral. While `busy` is high, the receiver must ignore line activity.

## Interface
- `INHIBIT_CYCLES`, 5000: system_clk cycles PS2_clk is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum cycles from clock release to ack sample (15 ms at 50 MHz).
- `system_clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `tx_data` in 8: byte to send; captured on accept.
- `tx_valid` in 1: request; accepted when `tx_valid && tx_ready`.
- `tx_ready` out 1: high only in IDLE.
- `PS2_clk` in 1: raw line value (asynchronous to system_clk).
- `PS2_data` in 1: raw line value.
- `ps2_clk_oe` out 1: 1 = drive PS2_clk low, 0 = release (pad is open-drain).
- `ps2_data_oe` out 1: 1 = drive PS2_data low, 0 = release.
- `busy` out 1: high in every state except IDLE.
- `tx_done` out 1: one-cycle pulse when the byte is acknowledged and the lines are idle.
- `tx_error` out 1: one-cycle pulse on timeout or missing ack.

## Operation
- PS2_clk and PS2_data each pass through a 2-flop synchronizer. A falling edge (`fall`) is synchronized-previous=1 and synchronized-current=0.
- Parity bit = ~^tx_data, which makes the 9-bit total an odd number of ones.
- Frame register holds {1 (stop), parity, data[7:0]}. A 4-bit bit counter `n` runs 0..10.
- States:
  - IDLE: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_ready`=1. On accept: capture the frame, load the inhibit counter, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then go to REQUEST.
  - REQUEST: 1 cycle with `ps2_data_oe`=1 and `ps2_clk_oe`=1. Next state is SEND with `ps2_clk_oe`=0, `n`=0, timeout counter cleared.
  - SEND: `ps2_data_oe` stays 1 (start bit) until the first `fall`. On each `fall` with `n`≤9: `ps2_data_oe` ← ~frame[n], then `n`++. Bit 9 (stop) therefore releases data. On `fall` with `n`=10: sample synchronized data.
    - 0 → go to WAIT_IDLE (ack).
    - 1 → set the error flag, go to WAIT_IDLE.
  - WAIT_IDLE: both oe=0. Stay until synchronized clk=1 and data=1 on the same cycle. Then pulse `tx_done` (or `tx_error` if the error flag is set), clear the flag, go to IDLE.
- Timeout: the counter runs in SEND only. When it reaches TIMEOUT_CYCLES, both oe go to 0, `tx_error` pulses, and the state goes straight to IDLE.
- `tx_valid` while not ready is ignored (not queued). `tx_data` changes after accept have no effect.

## Timing
- Reset values: `tx_ready`=1, `busy`=0, `tx_done`=0, `tx_error`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0, state IDLE, counters 0.
- `busy` rises and `ps2_clk_oe` asserts on the first edge after accept.
- `ps2_clk_oe` high for INHIBIT_CYCLES+1 cycles total (inhibit plus REQUEST).
- Data updates 3 system_clk cycles after the raw PS2_clk falling edge: 2 sync stages plus the output register.
- `tx_done` and `tx_error` are never asserted in the same cycle. `tx_ready` returns high the cycle after the pulse.
- Reset asserted mid-frame: both lines are released asynchronously, with no done or error pulse.
- A `fall` in any state other than SEND is ignored.

## Structure
- Shared package `ps2_pkg`:
  - state enum (IDLE, INHIBIT, REQUEST, SEND, WAIT_IDLE);
  - `PS2_SYNC_STAGES`=2;
  - odd-parity function;
  - frame-length constant 11.
- The receiver also uses this package.
- One sub-module, `ps2_line_sync`: 2-flop synchronizer plus falling-edge detect for one line. It is instantiated twice here and is reusable by the receiver.

## Test plan
Bench settings: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=4000. Device model: clocks at 40-cycle period after clock release, samples data on rising edges, acks by pulling data low during the 11th clock low phase.
- Send 0xED → device receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Ack → one `tx_done` pulse, no `tx_error`.
- Send 0x01 → parity 0. Send 0xFF → parity 1. Both acked with `tx_done`.
- Device never clocks → `tx_error` pulse exactly TIMEOUT_CYCLES cycles after entering SEND. Lines released; `tx_ready`=1 next cycle.
- Device leaves data high at the 11th fall → `tx_error` once the lines are idle, no `tx_done`.
- `reset` pulled low during bit 4 → `ps2_clk_oe`=`ps2_data_oe`=0 immediately. After release, a new 0xF4 transfer completes normally.
- `tx_valid` held high with changing `tx_data` during a transfer → only the first byte is sent. The next byte is accepted only after `tx_ready`=1.
